// File: rtl/ponylink_ioctl_pkg.sv
// Shared definitions for the ponylink I/O controller: the sequencing state
// enum, parameter defaults and a small sizing helper.
// Optional feature macro: PONYLINK_IOCTL_COLLDET_EN (collision detection).
package ponylink_ioctl_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        SERDES_RST = 2'd1,
        CORE_RST   = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam int DEF_PARBITS           = 4;
    localparam int DEF_LOCK_CYCLES       = 4;
    localparam int DEF_SERDES_RST_CYCLES = 8;
    localparam int DEF_CORE_RST_CYCLES   = 8;
    localparam int DEF_TRI_HOLD          = 3;
    localparam int DEF_COLL_LAT          = 2;

    // Largest of three phase lengths, used to size the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/ponylink_ioctl_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
// Cleared to 0 while resetn is low so a reset always restarts sequencing.
module ponylink_ioctl_sync (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Two-stage resynchronisation into the clk domain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/ponylink_ioctl.sv
// Ponylink I/O controller: sequences SERDES and core resets from PLL lock,
// converts per-bit drive enables into an OSERDES data word (undriven bits
// repeat the last driven value) plus a tristate control with hold-off, and
// forwards received words to the core while running.
// Optional feature macro: PONYLINK_IOCTL_COLLDET_EN compiles in readback
// collision detection; without it collision/coll_count are tied to 0.
//
// Handshake: there is no valid/ready flow control; every clk cycle carries
// exactly one word in each direction and the core must accept serdes_in on
// every cycle that core_resetn is high.
module ponylink_ioctl
    import ponylink_ioctl_pkg::*;
#(
    parameter int PARBITS           = DEF_PARBITS,
    parameter int LOCK_CYCLES       = DEF_LOCK_CYCLES,
    parameter int SERDES_RST_CYCLES = DEF_SERDES_RST_CYCLES,
    parameter int CORE_RST_CYCLES   = DEF_CORE_RST_CYCLES,
    parameter int TRI_HOLD          = DEF_TRI_HOLD,
    parameter int COLL_LAT          = DEF_COLL_LAT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pll_locked,
    output logic               serdes_rst,
    output logic               core_resetn,
    input  logic [PARBITS-1:0] serdes_out,
    input  logic [PARBITS-1:0] serdes_en,
    output logic [PARBITS-1:0] serdes_in,
    output logic [PARBITS-1:0] oserdes_d,
    output logic               oserdes_t,
    input  logic [PARBITS-1:0] iserdes_q,
    input  logic               coll_clr,
    output logic               collision,
    output logic [7:0]         coll_count,
    output state_t             dbg_state
);

    localparam int CNT_W  = $clog2(max3(LOCK_CYCLES, SERDES_RST_CYCLES, CORE_RST_CYCLES) + 1);
    localparam int HOLD_W = (TRI_HOLD > 1) ? $clog2(TRI_HOLD) : 1;

    logic              lock_s;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_ok;
    logic              last_q, last_d;
    logic [PARBITS-1:0] word_d;
    logic [HOLD_W-1:0] hold_q;

    ponylink_ioctl_sync u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_locked),
        .q      (lock_s)
    );

    assign dbg_state = state_q;

    // Datapath is live only in RUN with lock still present, so a lock drop
    // silences the pins on the same edge the FSM falls back to WAIT_LOCK.
    assign run_ok    = (state_q == RUN) && lock_s;
    assign serdes_in = (state_q == RUN) ? iserdes_q : '0;

    // Sequencing state, phase counter and registered reset outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            serdes_rst  <= 1'b1;
            core_resetn <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            serdes_rst  <= (state_d == WAIT_LOCK) || (state_d == SERDES_RST);
            core_resetn <= (state_d == RUN);
        end
    end

    // Next-state: count each phase to its length; losing lock aborts anywhere.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_d = SERDES_RST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SERDES_RST: begin
                    if (cnt_q == CNT_W'(SERDES_RST_CYCLES - 1)) begin
                        state_d = CORE_RST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CORE_RST: begin
                    if (cnt_q == CNT_W'(CORE_RST_CYCLES - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Bit scan: driven bits update "last", every bit takes the current "last".
    always_comb begin
        word_d = '0;
        last_d = last_q;
        for (int i = 0; i < PARBITS; i++) begin
            if (serdes_en[i]) last_d = serdes_out[i];
            word_d[i] = last_d;
        end
    end

    // Output word register and tristate hold-off countdown.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            oserdes_d <= '0;
            oserdes_t <= 1'b1;
            last_q    <= 1'b0;
            hold_q    <= '0;
        end else if (!run_ok) begin
            oserdes_d <= '0;
            oserdes_t <= 1'b1;
            last_q    <= 1'b0;
            hold_q    <= '0;
        end else begin
            oserdes_d <= word_d;
            last_q    <= last_d;
            if (|serdes_en) begin
                oserdes_t <= 1'b0;
                hold_q    <= HOLD_W'(TRI_HOLD - 1);
            end else if (hold_q != '0) begin
                oserdes_t <= 1'b0;
                hold_q    <= hold_q - HOLD_W'(1);
            end else begin
                oserdes_t <= 1'b1;
            end
        end
    end

`ifdef PONYLINK_IOCTL_COLLDET_EN
    // Entry layout: [PARBITS:1] = driven word, [0] = drive active.
    logic [PARBITS:0] coll_pipe [COLL_LAT];
    logic [PARBITS:0] coll_dly;
    logic             coll_hit;

    assign coll_dly = coll_pipe[COLL_LAT-1];
    assign coll_hit = coll_dly[0] && (coll_dly[PARBITS:1] != iserdes_q);

    // Delay the drive word to line up with its readback.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < COLL_LAT; i++) coll_pipe[i] <= '0;
        end else begin
            coll_pipe[0] <= {oserdes_d, ~oserdes_t};
            for (int i = 1; i < COLL_LAT; i++) coll_pipe[i] <= coll_pipe[i-1];
        end
    end

    // Sticky flag and saturating count; clearing beats a same-cycle hit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            collision  <= 1'b0;
            coll_count <= '0;
        end else if (coll_clr || !run_ok) begin
            collision  <= 1'b0;
            coll_count <= '0;
        end else if (coll_hit) begin
            collision <= 1'b1;
            if (coll_count != 8'hFF) coll_count <= coll_count + 8'd1;
        end
    end
`else
    localparam int unused_coll_lat = COLL_LAT;
    logic unused_coll_clr;

    assign unused_coll_clr = coll_clr;
    assign collision       = 1'b0;
    assign coll_count      = '0;
`endif

endmodule

// File: tb/tb_ponylink_ioctl.sv
// Self-checking bench for ponylink_ioctl: reset sequencing, lock loss,
// hold-last word building, tristate hold-off and collision counting,
// compared against a cycle-level behavioural model kept in the bench.
module tb_ponylink_ioctl;
    import ponylink_ioctl_pkg::*;

    localparam int PB = 4;
    localparam int TH = 3;
    localparam int CL = 2;
    localparam int W  = PB + 1;

`ifdef PONYLINK_IOCTL_COLLDET_EN
    localparam bit COLLDET = 1'b1;
`else
    localparam bit COLLDET = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          pll_locked = 1'b0;
    logic [PB-1:0] serdes_out = '0;
    logic [PB-1:0] serdes_en = '0;
    logic [PB-1:0] iserdes_q = '0;
    logic          coll_clr = 1'b0;
    logic          serdes_rst, core_resetn, oserdes_t, collision;
    logic [PB-1:0] serdes_in, oserdes_d;
    logic [7:0]    coll_count;
    state_t        dbg_state;

    always #5 clk = ~clk;

    ponylink_ioctl dut (
        .clk         (clk),
        .resetn      (resetn),
        .pll_locked  (pll_locked),
        .serdes_rst  (serdes_rst),
        .core_resetn (core_resetn),
        .serdes_out  (serdes_out),
        .serdes_en   (serdes_en),
        .serdes_in   (serdes_in),
        .oserdes_d   (oserdes_d),
        .oserdes_t   (oserdes_t),
        .iserdes_q   (iserdes_q),
        .coll_clr    (coll_clr),
        .collision   (collision),
        .coll_count  (coll_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int            checks = 0;
    int            errors = 0;
    int            low_cnt = 0;
    logic [W-1:0]  exp_q[$];   // {word, tristate} expected after next edge
    logic [W-1:0]  hist[$];    // {word, drive} expected per elapsed cycle
    logic          m_last;
    int            m_since;
    logic          m_coll;
    int            m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset_run();
        m_last  = 1'b0;
        m_since = TH;
        m_coll  = 1'b0;
        m_cnt   = 0;
        exp_q.delete();
        hist.delete();
        for (int i = 0; i <= CL; i++) hist.push_back('0);
    endtask

    // ---------------- driver tasks ----------------
    // mode: 0 random readback, 1 echo of the delayed drive, 2 inverted echo.
    task automatic drive_word(input logic [PB-1:0] en, input logic [PB-1:0] out,
                              input int mode, input logic clr);
        logic [W-1:0]  dly;
        logic [W-1:0]  e;
        logic [PB-1:0] q;
        logic [PB-1:0] w;
        dly = hist[hist.size() - 1 - CL];
        case (mode)
            1:       q = dly[W-1:1];
            2:       q = ~dly[W-1:1];
            default: q = PB'($urandom);
        endcase
        serdes_en  = en;
        serdes_out = out;
        iserdes_q  = q;
        coll_clr   = clr;
        #1;
        check("serdes_in", 32'(serdes_in), 32'(q));
        if (COLLDET) begin
            if (clr) begin
                m_coll = 1'b0;
                m_cnt  = 0;
            end else if (dly[0] && (dly[W-1:1] != q)) begin
                m_coll = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        for (int i = 0; i < PB; i++) begin
            if (en[i]) m_last = out[i];
            w[i] = m_last;
        end
        if (en != '0) m_since = 0;
        else if (m_since < TH) m_since++;
        exp_q.push_back({w, (m_since < TH) ? 1'b0 : 1'b1});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("oserdes_d", 32'(oserdes_d), 32'(e[W-1:1]));
        check("oserdes_t", 32'(oserdes_t), 32'(e[0]));
        check("collision", 32'(collision), 32'(m_coll));
        check("coll_count", 32'(coll_count), 32'(m_cnt));
        if (!oserdes_t) low_cnt++;
        hist.push_back({e[W-1:1], ~e[0]});
        void'(hist.pop_front());
        coll_clr = 1'b0;
    endtask

    // Raise lock and measure the two reset release delays in clock edges.
    task automatic bring_up();
        int n;
        check("pre_lock_serdes_rst", 32'(serdes_rst), 32'd1);
        pll_locked = 1'b1;
        n = 0;
        while (serdes_rst === 1'b1 && n < 100) begin
            serdes_en  = PB'($urandom);
            serdes_out = PB'($urandom);
            tick();
            n++;
            if (oserdes_t !== 1'b1) check("idle_oserdes_t", 32'(oserdes_t), 32'd1);
        end
        check("lock_to_serdes_rst_fall", n, 32'd14);
        n = 0;
        while (core_resetn !== 1'b1 && n < 100) begin
            serdes_en  = PB'($urandom);
            serdes_out = PB'($urandom);
            iserdes_q  = '1;
            tick();
            n++;
            if (core_resetn !== 1'b1) check("pre_run_serdes_in", 32'(serdes_in), 32'd0);
        end
        check("serdes_rst_to_core_resetn", n, 32'd8);
        check("run_state", 32'(dbg_state), 32'(RUN));
        check("run_entry_oserdes_t", 32'(oserdes_t), 32'd1);
        check("run_entry_oserdes_d", 32'(oserdes_d), 32'd0);
        model_reset_run();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Reset: everything forced regardless of inputs.
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serdes_en  = PB'($urandom);
            serdes_out = PB'($urandom);
            iserdes_q  = '1;
            tick();
        end
        check("rst_state", 32'(dbg_state), 32'(WAIT_LOCK));
        check("rst_serdes_rst", 32'(serdes_rst), 32'd1);
        check("rst_core_resetn", 32'(core_resetn), 32'd0);
        check("rst_oserdes_d", 32'(oserdes_d), 32'd0);
        check("rst_oserdes_t", 32'(oserdes_t), 32'd1);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_coll_count", 32'(coll_count), 32'd0);
        check("rst_serdes_in", 32'(serdes_in), 32'd0);

        resetn = 1'b1;
        repeat (4) tick();
        check("no_lock_serdes_rst", 32'(serdes_rst), 32'd1);
        check("no_lock_core_resetn", 32'(core_resetn), 32'd0);

        bring_up();

        // Hold-last: one driven low bit fills the word, and carries over.
        drive_word(4'b0000, 4'b0000, 1, 1'b0);
        drive_word(4'b0001, 4'b0001, 1, 1'b0);
        check("hold_last_w0", 32'(oserdes_d), 32'hF);
        drive_word(4'b0000, 4'b0000, 1, 1'b0);
        check("hold_last_w1", 32'(oserdes_d), 32'hF);

        // Tristate hold: single pulse, then two pulses two cycles apart.
        repeat (4) drive_word(4'b0000, PB'($urandom), 1, 1'b0);
        low_cnt = 0;
        drive_word(4'b0010, PB'($urandom), 1, 1'b0);
        repeat (7) drive_word(4'b0000, PB'($urandom), 1, 1'b0);
        check("tri_hold_single", low_cnt, 32'd3);
        low_cnt = 0;
        drive_word(4'b1000, PB'($urandom), 1, 1'b0);
        drive_word(4'b0000, PB'($urandom), 1, 1'b0);
        drive_word(4'b0100, PB'($urandom), 1, 1'b0);
        repeat (7) drive_word(4'b0000, PB'($urandom), 1, 1'b0);
        check("tri_hold_restart", low_cnt, 32'd5);

        // Randomized traffic with occasional bad readback and clears.
        for (int i = 0; i < 200; i++) begin
            drive_word(($urandom_range(0, 2) == 0) ? 4'b0000 : PB'($urandom),
                       PB'($urandom),
                       ($urandom_range(0, 3) == 0) ? 0 : 1,
                       ($urandom_range(0, 19) == 0));
        end

        // Collision saturation and clear.
        drive_word(4'b0000, 4'b0000, 1, 1'b1);
        for (int i = 0; i < 300; i++) drive_word(4'b1111, PB'($urandom), 2, 1'b0);
        check("coll_sat_flag", 32'(collision), COLLDET ? 32'd1 : 32'd0);
        check("coll_sat_count", 32'(coll_count), COLLDET ? 32'd255 : 32'd0);
        drive_word(4'b0000, 4'b0000, 2, 1'b1);
        check("coll_clr_flag", 32'(collision), 32'd0);
        check("coll_clr_count", 32'(coll_count), 32'd0);

        // Loss of lock while driving.
        for (int i = 0; i < 5; i++) drive_word(4'b1111, PB'($urandom), 2, 1'b0);
        pll_locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serdes_en  = 4'b1111;
            serdes_out = PB'($urandom);
            iserdes_q  = '1;
            tick();
        end
        check("lol_core_resetn", 32'(core_resetn), 32'd0);
        check("lol_serdes_rst", 32'(serdes_rst), 32'd1);
        check("lol_oserdes_t", 32'(oserdes_t), 32'd1);
        check("lol_oserdes_d", 32'(oserdes_d), 32'd0);
        check("lol_collision", 32'(collision), 32'd0);
        check("lol_coll_count", 32'(coll_count), 32'd0);
        check("lol_serdes_in", 32'(serdes_in), 32'd0);
        check("lol_state", 32'(dbg_state), 32'(WAIT_LOCK));

        // Relock: counters must have restarted from zero.
        repeat (4) tick();
        bring_up();
        for (int i = 0; i < 40; i++) begin
            drive_word(($urandom_range(0, 1) == 0) ? 4'b0000 : PB'($urandom),
                       PB'($urandom), 1, 1'b0);
        end

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so a stuck DUT cannot hang the run.
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
